// File: rtl/mux2x_pkg.sv
// Shared constants for the registered 2:1 word multiplexer family:
// legal data widths, the reset word and the select encoding.
package mux2x_pkg;

    localparam int WIDTH_16 = 16;
    localparam int WIDTH_24 = 24;
    localparam int WIDTH_32 = 32;
    localparam int WIDTH_MAX = WIDTH_32;

    // Reset value of the output register, sliced down to the instance width.
    localparam logic [WIDTH_MAX-1:0] RST_WORD = '0;

    typedef enum logic {
        SEL_IN0 = 1'b0,
        SEL_IN1 = 1'b1
    } sel_e;

    function automatic bit width_legal(input int w);
        return (w == WIDTH_16) || (w == WIDTH_24) || (w == WIDTH_32);
    endfunction

endpackage

// File: rtl/mux2X16.sv
// 16-bit instance of the registered 2:1 word multiplexer.
module mux2X16 (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] in0,
    input  logic [15:0] in1,
    input  logic        sel,
    input  logic        in_valid,
    output logic [15:0] out,
    output logic        out_valid
);

    mux2x #(
        .WIDTH (16)
    ) u_mux2x (
        .clk       (clk),
        .rst       (rst),
        .in0       (in0),
        .in1       (in1),
        .sel       (sel),
        .in_valid  (in_valid),
        .out       (out),
        .out_valid (out_valid)
    );

endmodule

// File: rtl/mux2X24.sv
// 24-bit instance of the registered 2:1 word multiplexer.
module mux2X24 (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] in0,
    input  logic [23:0] in1,
    input  logic        sel,
    input  logic        in_valid,
    output logic [23:0] out,
    output logic        out_valid
);

    mux2x #(
        .WIDTH (24)
    ) u_mux2x (
        .clk       (clk),
        .rst       (rst),
        .in0       (in0),
        .in1       (in1),
        .sel       (sel),
        .in_valid  (in_valid),
        .out       (out),
        .out_valid (out_valid)
    );

endmodule

// File: rtl/mux2X32.sv
// 32-bit instance of the registered 2:1 word multiplexer.
module mux2X32 (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] in0,
    input  logic [31:0] in1,
    input  logic        sel,
    input  logic        in_valid,
    output logic [31:0] out,
    output logic        out_valid
);

    mux2x #(
        .WIDTH (32)
    ) u_mux2x (
        .clk       (clk),
        .rst       (rst),
        .in0       (in0),
        .in1       (in1),
        .sel       (sel),
        .in_valid  (in_valid),
        .out       (out),
        .out_valid (out_valid)
    );

endmodule

// File: rtl/mux2x_comb.sv
// Combinational 2:1 word select; sel=0 passes in0, sel=1 passes in1,
// every bit taken unchanged.
module mux2x_comb
    import mux2x_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic             sel,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = in0;
        if (sel_e'(sel) == SEL_IN1) begin
            y = in1;
        end
    end

endmodule

// File: rtl/mux2x.sv
// Registered 2:1 word multiplexer with a valid qualifier: one cycle of
// latency, holds its output when no valid word arrives, synchronous reset.
module mux2x
    import mux2x_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic             sel,
    input  logic             in_valid,
    output logic [WIDTH-1:0] out,
    output logic             out_valid
);

    generate
        if (!width_legal(WIDTH)) begin : g_bad_width
            $error("mux2x: WIDTH must be 16, 24 or 32");
        end
    endgenerate

    logic [WIDTH-1:0] sel_word;
    logic [WIDTH-1:0] out_d;
    logic [WIDTH-1:0] out_q;
    logic             out_valid_d;
    logic             out_valid_q;

    mux2x_comb #(
        .WIDTH (WIDTH)
    ) u_comb (
        .in0 (in0),
        .in1 (in1),
        .sel (sel),
        .y   (sel_word)
    );

    always_comb begin
        out_d       = out_q;
        out_valid_d = in_valid;
        if (in_valid) begin
            out_d = sel_word;
        end
    end

    // Reset wins over a coincident valid word.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q       <= RST_WORD[WIDTH-1:0];
            out_valid_q <= 1'b0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux2x.sv
// Bench for mux2x: three instances (16/24/32 bits) share one stimulus
// stream, each sliced to its width, and are compared against a reference.
module tb_mux2x;

    logic        clk;
    logic        rst;
    logic [31:0] in0;
    logic [31:0] in1;
    logic        sel;
    logic        in_valid;

    logic [15:0] out16;
    logic [23:0] out24;
    logic [31:0] out32;
    logic        ov16;
    logic        ov24;
    logic        ov32;

    int checks = 0;
    int errors = 0;

    // Reference: every accepted word is appended; out is the newest one.
    logic [31:0] accepted[$];
    logic [31:0] exp_out;
    logic        exp_vld;

    mux2x #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .in0(in0[15:0]), .in1(in1[15:0]), .sel(sel),
        .in_valid(in_valid), .out(out16), .out_valid(ov16)
    );
    mux2x #(.WIDTH(24)) dut24 (
        .clk(clk), .rst(rst), .in0(in0[23:0]), .in1(in1[23:0]), .sel(sel),
        .in_valid(in_valid), .out(out24), .out_valid(ov24)
    );
    mux2x #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .in0(in0), .in1(in1), .sel(sel),
        .in_valid(in_valid), .out(out32), .out_valid(ov32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        if (rst) begin
            accepted.delete();
            exp_out = '0;
            exp_vld = 1'b0;
        end else begin
            exp_vld = in_valid;
            if (in_valid) begin
                accepted.push_back(sel ? in1 : in0);
                if (accepted.size() > 8) void'(accepted.pop_front());
            end
            exp_out = (accepted.size() != 0) ? accepted[$] : 32'h0;
        end
        #1;
    endtask

    task automatic check(input string tag);
        checks++;
        assert (out16 === exp_out[15:0]) else begin
            errors++;
            $error("FAIL %s out16 got %h exp %h", tag, out16, exp_out[15:0]);
        end
        checks++;
        assert (out24 === exp_out[23:0]) else begin
            errors++;
            $error("FAIL %s out24 got %h exp %h", tag, out24, exp_out[23:0]);
        end
        checks++;
        assert (out32 === exp_out) else begin
            errors++;
            $error("FAIL %s out32 got %h exp %h", tag, out32, exp_out);
        end
        checks++;
        assert ({ov16, ov24, ov32} === {3{exp_vld}}) else begin
            errors++;
            $error("FAIL %s out_valid got %b%b%b exp %b", tag, ov16, ov24, ov32, exp_vld);
        end
    endtask

    task automatic check_word(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s got %h exp %h", tag, got, want);
        end
    endtask

    initial begin
        exp_out  = '0;
        exp_vld  = 1'b0;
        rst      = 1'b1;
        in_valid = 1'b1;
        sel      = 1'($urandom_range(0, 1));
        in0      = $urandom;
        in1      = $urandom;

        // Reset for two cycles with arbitrary inputs.
        step();
        in0 = $urandom; in1 = $urandom; sel = ~sel;
        step();
        check("reset");
        check_word("reset_out32", out32, 32'h0);
        check_word("reset_vld", {31'b0, ov16}, 32'h0);

        // First edge out of reset loads.
        rst = 1'b0; in_valid = 1'b1; sel = 1'b0; in0 = 32'h0000_1234; in1 = $urandom;
        step();
        check("rst_release");
        check_word("rst_release_out16", {16'b0, out16}, 32'h1234);
        check_word("rst_release_vld", {31'b0, ov16}, 32'h1);

        // Shift-stage pattern on the 24-bit instance.
        in0 = 32'd10000000; in1 = 32'd5000000; sel = 1'b1;
        step();
        check("shift_sel1");
        check_word("shift_sel1_out24", {8'b0, out24}, 32'd5000000);
        sel = 1'b0;
        step();
        check("shift_sel0");
        check_word("shift_sel0_out24", {8'b0, out24}, 32'd10000000);

        // Full-width toggle, back-to-back valid.
        in0 = 32'hFFFF_FFFF; in1 = 32'h0;
        for (int i = 0; i < 8; i++) begin
            sel = i[0];
            step();
            check("toggle");
            check_word("toggle_out32", out32, sel ? 32'h0 : 32'hFFFF_FFFF);
        end

        // Hold with in_valid low.
        sel = 1'b0; in0 = 32'h0000_A5A5; in1 = $urandom;
        step();
        check("hold_load");
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in0 = $urandom; in1 = $urandom; sel = ~sel;
            step();
            check("hold");
            check_word("hold_out16", {16'b0, out16}, 32'hA5A5);
            check_word("hold_vld", {31'b0, ov16}, 32'h0);
        end

        // Reset raised between edges has no immediate effect.
        in_valid = 1'b1; sel = 1'b1; in1 = 32'hDEAD_BEEF;
        step();
        rst = 1'b1;
        #2;
        check("rst_sync_pre");
        check_word("rst_sync_pre_out32", out32, 32'hDEAD_BEEF);

        // Reset beats a coincident valid word.
        in_valid = 1'b1; in0 = $urandom; in1 = $urandom;
        step();
        check("rst_priority");
        check_word("rst_priority_out32", out32, 32'h0);
        rst = 1'b0;

        // Equal operands: select is irrelevant.
        for (int i = 0; i < 4; i++) begin
            in0 = $urandom; in1 = in0; sel = 1'($urandom_range(0, 1));
            step();
            check("equal");
            check_word("equal_out32", out32, in0);
        end

        // Randomised run.
        for (int i = 0; i < 1200; i++) begin
            rst      = ($urandom_range(0, 49) == 0);
            in_valid = ($urandom_range(0, 9) < 7);
            sel      = 1'($urandom_range(0, 1));
            in0      = $urandom;
            in1      = $urandom;
            step();
            check("random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux2x.md
MUX2X -- requirements
Module: mux2x

Interface
REQ-001 Parameter: WIDTH, default 16, data word width in bits; legal values 16, 24, 32.
REQ-002 Port: clk  input  1  rising-edge clock; the block has one clock.
REQ-003 Port: rst  input  1  reset; synchronous and active-high.
REQ-004 Port: in0  input  WIDTH  data selected when sel=0 (pass-through operand).
REQ-005 Port: in1  input  WIDTH  data selected when sel=1 (e.g. shifted operand of a shifter stage).
REQ-006 Port: sel  input  1  select.
REQ-007 Port: in_valid  input  1  qualifies in0/in1/sel this cycle.
REQ-008 Port: out  output  WIDTH  registered selected word.
REQ-009 Port: out_valid  output  1  registered copy of in_valid.

Function
REQ-010 Selection SHALL be: sel=0 gives in0, sel=1 gives in1, all WIDTH bits, with no bit reordering, extension or truncation.
REQ-011 Latency SHALL be exactly 1 clk cycle: the selection made at edge N appears on out after edge N and stays stable until the next load.
REQ-012 out SHALL load the selected word only on edges where in_valid=1 and rst=0.
REQ-013 out SHALL hold its previous value on edges where in_valid=0.
REQ-014 out_valid SHALL equal in_valid sampled at the previous edge, and SHALL be 0 after reset.
REQ-015 There is no backpressure; every in_valid=1 cycle SHALL be accepted.
REQ-016 Back-to-back valid cycles SHALL produce back-to-back results with no bubble.
REQ-017 When in0 and in1 are equal, out SHALL equal that value regardless of sel.
REQ-018 out SHALL depend only on sampled inputs and reset; there is no internal state other than the out and out_valid registers.

Reset
REQ-019 When rst=1 at a rising clk edge, out SHALL become all-zeros and out_valid SHALL become 0.
REQ-020 rst SHALL take priority over in_valid on the same edge.
REQ-021 Reset is synchronous, so an asserted rst SHALL have no effect until the next rising edge.
REQ-022 On the first edge with rst=0, the block SHALL operate normally, including loading if in_valid=1.

Structure
REQ-023 A shared package SHALL hold the legal width constants 16, 24 and 32 and the reset value (zero word).
REQ-024 The combinational 2:1 word select SHALL be one sub-module, mux2x_comb (WIDTH-parameterised, no clock), instantiated inside mux2x ahead of the output register.
REQ-025 Thin wrappers mux2X16, mux2X24 and mux2X32 SHALL instantiate mux2x with WIDTH=16, 24 and 32 respectively, with identical port lists.
REQ-026 mux2x SHALL check WIDTH at elaboration and fail on illegal values.

Verification
REQ-027 Reset check: assert rst for 2 cycles with arbitrary inputs -> out=0 and out_valid=0; release rst, drive in_valid=1, sel=0, in0=16'h1234 -> one cycle later out=16'h1234 and out_valid=1.
REQ-028 Shift-stage check, WIDTH=24: in0=24'd10000000, in1=in0>>1=24'd5000000, sel=1, in_valid=1 -> next cycle out=24'd5000000; repeat with sel=0 -> out=24'd10000000.
REQ-029 Full-width check, WIDTH=32: in0=32'hFFFF_FFFF, in1=32'h0000_0000; toggle sel every cycle with in_valid=1 -> out alternates with exactly 1-cycle lag and all bits move together.
REQ-030 Hold check: load 16'hA5A5, then drive in_valid=0 for 3 cycles with changing in0/in1/sel -> out stays 16'hA5A5 and out_valid=0.
REQ-031 Reset priority: rst=1 and in_valid=1 on the same edge -> out=0 and out_valid=0.
REQ-032 Randomised run for each WIDTH (16, 24, 32): out SHALL match a scoreboard model of REQ-010 to REQ-014 for at least 1000 cycles.
